// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter in front of a single UART transmitter
// send port. Each requester holds a level request with its byte. One winner
// is granted and its byte is latched. The arbiter then runs the 4-phase
// send_req/send_ack handshake and reports done or err back to the winner.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset
//   req            level request, one bit per requester
//   req_data       packed bytes; requester i at [i*DATA_SIZE +: DATA_SIZE]
//   done           one-cycle pulse: byte of requester i accepted
//   err            one-cycle pulse: transfer of requester i timed out
//   busy           high whenever not IDLE
//   grant_idx      index of current or last winner
//   uart_send_req  request to the transmitter
//   uart_send_ack  acknowledge from the transmitter
//   uart_din       latched byte, stable while uart_send_req is high
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int TIMEOUT   = 1048575,
  parameter int IDX_W     = $clog2(NUM_REQ),
  parameter int TO_W      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           done,
  output logic [NUM_REQ-1:0]           err,
  output logic                         busy,
  output logic [IDX_W-1:0]             grant_idx,
  output logic                         uart_send_req,
  input  logic                         uart_send_ack,
  output logic [DATA_SIZE-1:0]         uart_din
);

  localparam int unsigned N = NUM_REQ;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [TO_W-1:0]   cnt;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  nxt_ptr;

  // First set request bit at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned j;
    logic        found;
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    nxt_ptr = '0;
    if (grant_idx != IDX_W'(N - 1)) nxt_ptr = grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      grant_idx     <= '0;
      uart_din      <= '0;
      uart_send_req <= 1'b0;
      busy          <= 1'b0;
      done          <= '0;
      err           <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_idx     <= win;
            uart_din      <= req_data[win*DATA_SIZE +: DATA_SIZE];
            uart_send_req <= 1'b1;
            busy          <= 1'b1;
            cnt           <= '0;
            state         <= SEND;
          end
        end
        SEND: begin
          if (uart_send_ack) begin
            uart_send_req   <= 1'b0;
            done[grant_idx] <= 1'b1;
            ptr             <= nxt_ptr;
            state           <= RELEASE;
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            uart_send_req  <= 1'b0;
            err[grant_idx] <= 1'b1;
            ptr            <= nxt_ptr;
            state          <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          // Hold off the next grant until ack is seen low, so send_req never
          // rises while the transmitter still drives ack.
          if (!uart_send_ack) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_SIZE=8, TIMEOUT=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  done;
  logic [3:0]  err;
  logic        busy;
  logic [1:0]  grant_idx;
  logic        uart_send_req;
  logic        uart_send_ack;
  logic [7:0]  uart_din;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ  (4),
    .DATA_SIZE(8),
    .TIMEOUT  (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_data     (req_data),
    .done         (done),
    .err          (err),
    .busy         (busy),
    .grant_idx    (grant_idx),
    .uart_send_req(uart_send_req),
    .uart_send_ack(uart_send_ack),
    .uart_din     (uart_din)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  req_mid;
    logic [31:0] data;
    int          dly;
    int          hold;
    int          exp_idx;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_send_req(input string name);
    int k;
    k = 0;
    while (!uart_send_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_req_rise"}, 32'(uart_send_req), 32'd1);
  endtask

  task automatic xfer(input string name, input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.exp_idx;
    req      = v.req;
    req_data = v.data;
    @(negedge clk);
    wait_send_req(name);
    chk({name, "_idx"}, 32'(grant_idx), 32'(v.exp_idx));
    chk({name, "_din"}, 32'(uart_din), 32'(v.exp_byte));
    chk({name, "_busy"}, 32'(busy), 32'd1);
    // Late data change must not reach uart_din.
    req      = v.req_mid;
    req_data = ~v.data;
    repeat (v.dly) @(negedge clk);
    uart_send_ack = 1'b1;
    @(negedge clk);
    chk({name, "_done"}, 32'(done), 32'(oh));
    chk({name, "_err"}, 32'(err), 32'd0);
    chk({name, "_req_fall"}, 32'(uart_send_req), 32'd0);
    chk({name, "_din_held"}, 32'(uart_din), 32'(v.exp_byte));
    for (int i = 1; i < v.hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_done"}, 32'(done), 32'd0);
      chk({name, "_hold_req"}, 32'(uart_send_req), 32'd0);
      chk({name, "_hold_busy"}, 32'(busy), 32'd1);
    end
    uart_send_ack = 1'b0;
    @(negedge clk);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({name, "_idle_req"}, 32'(uart_send_req), 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_req"}, 32'(uart_send_req), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_err"}, 32'(err), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_idx"}, 32'(grant_idx), 32'd0);
    chk({name, "_din"}, 32'(uart_din), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ptr after each vector is noted for the hand-computed expectations.
    vecs[0]  = '{4'b1111, 4'b1111, 32'h13121110, 3, 2, 0, 8'h10}; // ptr 1
    vecs[1]  = '{4'b1111, 4'b1111, 32'h13121110, 3, 2, 1, 8'h11}; // ptr 2
    vecs[2]  = '{4'b1111, 4'b1111, 32'h13121110, 3, 2, 2, 8'h12}; // ptr 3
    vecs[3]  = '{4'b1111, 4'b1111, 32'h13121110, 3, 2, 3, 8'h13}; // ptr 0
    vecs[4]  = '{4'b0001, 4'b0001, 32'h000000A5, 3, 2, 0, 8'hA5}; // ptr 1
    vecs[5]  = '{4'b0001, 4'b0101, 32'h00660055, 1, 1, 0, 8'h55}; // ptr 1
    vecs[6]  = '{4'b0101, 4'b0101, 32'h00660055, 2, 1, 2, 8'h66}; // ptr 3
    vecs[7]  = '{4'b0101, 4'b0101, 32'h00660055, 2, 1, 0, 8'h55}; // ptr 1
    vecs[8]  = '{4'b0101, 4'b0101, 32'h00660055, 2, 1, 2, 8'h66}; // ptr 3
    vecs[9]  = '{4'b0101, 4'b0101, 32'h00660055, 2, 1, 0, 8'h55}; // ptr 1
    vecs[10] = '{4'b0010, 4'b0000, 32'h0000BB00, 0, 10, 1, 8'hBB}; // held ack

    reset_n       = 1'b0;
    req           = '0;
    req_data      = '0;
    uart_send_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Ack high in IDLE without requests must not start anything.
    uart_send_ack = 1'b1;
    @(negedge clk);
    chk("idle_ack_busy", 32'(busy), 32'd0);
    uart_send_ack = 1'b0;

    for (int i = 0; i < 10; i++) xfer($sformatf("vec%0d", i), vecs[i]);

    // Timeout: requesters 2 and 3 request, ptr=1 so 2 wins; no ack.
    req      = 4'b1100;
    req_data = 32'h77CC0000;
    @(negedge clk);
    wait_send_req("to");
    chk("to_idx", 32'(grant_idx), 32'd2);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k < 16) begin
        chk("to_wait_err", 32'(err), 32'd0);
        chk("to_wait_req", 32'(uart_send_req), 32'd1);
      end else begin
        chk("to_err", 32'(err), 32'b0100);
        chk("to_req_fall", 32'(uart_send_req), 32'd0);
      end
      chk("to_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("to_err_pulse", 32'(err), 32'd0);
    chk("to_idle_busy", 32'(busy), 32'd0);
    xfer("after_to", '{4'b1100, 4'b1100, 32'h77CC0000, 2, 1, 3, 8'h77}); // ptr 0

    xfer("held_ack", vecs[10]); // ptr 2

    // Reset mid-SEND: requester 1 granted, reset for one cycle.
    req      = 4'b0010;
    req_data = 32'h0000DD00;
    @(negedge clk);
    wait_send_req("rst");
    chk("rst_idx", 32'(grant_idx), 32'd1);
    req     = 4'b1111;
    reset_n = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid");
    reset_n = 1'b1;
    xfer("post_rst", '{4'b1111, 4'b1111, 32'h44332211, 2, 1, 0, 8'h11});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single `uart_transmitter` send port among `NUM_REQ` independent requesters. Each requester presents a byte with a level request. The arbiter picks one winner, latches its byte, and runs the 4-phase `send_req`/`send_ack` handshake with the transmitter. It then signals completion or timeout back to that requester. It sits between client logic and the `uart` top's `send_req`/`send_ack`/`din` pins.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `DATA_SIZE`, default 8: byte width; must match the transmitter.
- `TIMEOUT`, default 1048575: maximum cycles to wait for `uart_send_ack` rising. 0 disables the timeout.
- `IDX_W`, default `$clog2(NUM_REQ)`: width of the grant index.
- `TO_W`, default `$clog2(TIMEOUT+1)`: width of the timeout counter (minimum 1).
- `clk`, in, 1: the single clock; all logic on its rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `req`, in, `NUM_REQ`: level request per requester.
- `req_data`, in, `NUM_REQ*DATA_SIZE`: byte of requester i at slice `[i*DATA_SIZE +: DATA_SIZE]`.
- `done`, out, `NUM_REQ`: one-cycle pulse; the byte of requester i was accepted by the transmitter.
- `err`, out, `NUM_REQ`: one-cycle pulse; the transfer of requester i timed out.
- `busy`, out, 1: high whenever the state is not IDLE.
- `grant_idx`, out, `IDX_W`: index of the current or last winner.
- `uart_send_req`, out, 1: request to the transmitter.
- `uart_send_ack`, in, 1: acknowledge from the transmitter.
- `uart_din`, out, `DATA_SIZE`: byte to the transmitter; registered, stable while `uart_send_req`=1.

## Operation
**State machine: IDLE, SEND, RELEASE.**

**IDLE**
- If `req` is nonzero, select the first set bit searching upward from `ptr`, wrapping modulo `NUM_REQ`.
- Next edge: `grant_idx` := winner, `uart_din` := winner's slice, `uart_send_req` := 1, state := SEND.
- The timeout counter clears to 0 on entering SEND.

**SEND**
- `uart_send_ack`=1 sampled:
  - `uart_send_req` := 0.
  - `done[grant_idx]` pulses for 1 cycle.
  - `ptr` := (`grant_idx`+1) mod `NUM_REQ`.
  - State := RELEASE.
- Else, if `TIMEOUT`≠0 and the counter equals `TIMEOUT`-1:
  - `uart_send_req` := 0.
  - `err[grant_idx]` pulses.
  - `ptr` advances as above.
  - State := RELEASE.
- Else the counter increments.

**RELEASE**
- Wait for `uart_send_ack`=0 sampled, then state := IDLE.
- There is no timeout in RELEASE.

**General rules**
- `ptr` resets to 0 and changes only on `done` or `err`. This guarantees each active requester is served at least once every `NUM_REQ` transfers.
- `req`/`req_data` are sampled only in IDLE.
  - A requester that drops `req` during SEND still gets `done` or `err`.
  - Changing `req_data` after the grant has no effect.
- Requester rule: keep `req` high until `done`/`err`. To send the next byte, update `req_data` in the cycle after the pulse and keep `req` high. That requester competes again in the next IDLE cycle, with lowest priority.
- At most one bit of `done|err` is set in any cycle. `done` and `err` are never set together.
- `uart_send_ack` high while in IDLE is ignored. A new grant waits until the state passes through RELEASE, so `uart_send_req` never rises while `uart_send_ack`=1.

**Reset (`reset_n`=0 at an edge, in any state, including mid-SEND)**
- State := IDLE.
- `uart_send_req`, `done`, `err`, `busy` := 0.
- `grant_idx`, `ptr`, `uart_din`, counter := 0.
- No `done`/`err` is issued for the aborted transfer.

## Timing
- `req` sampled in IDLE at edge t: `uart_send_req`=1 and `busy`=1 from t+1.
- `uart_send_ack` sampled 1 at edge s: `uart_send_req`=0 and `done` pulse at s+1.
- `uart_send_ack` sampled 0 at edge r in RELEASE: state is IDLE at r+1, and a new grant can be asserted at r+2.
- Minimum back-to-back spacing is therefore 4 cycles plus transmitter ack latency.
- Timeout: if `uart_send_ack` never rises, `err` appears `TIMEOUT` cycles after `uart_send_req` rose.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Single requester.** `req`=0001, data 0xA5; transmitter acks after 3 cycles, then drops ack 2 cycles later.
  - Expect `uart_din`=0xA5, `grant_idx`=0, one `done[0]` pulse, `busy` low after RELEASE.
- **All four requesters.** `req`=1111 simultaneously, data 0x10..0x13.
  - Expect grants in order 0,1,2,3 and bytes 0x10,0x11,0x12,0x13 on `uart_din`, with one `done` pulse each.
- **Fairness.** `req[0]` held high continuously; `req[2]` raised during the first transfer.
  - Expect the grant sequence 0,2,0,2…; requester 2 is never starved.
- **Timeout.** `TIMEOUT`=16, `req`=0100, no ack.
  - Expect `err[2]` 16 cycles after `uart_send_req` rose, `uart_send_req` dropped, no `done`.
  - The next grant goes to requester 3 if it is requesting.
- **Reset mid-SEND.** Assert `reset_n`=0 for 1 cycle while `uart_send_req`=1.
  - Expect all outputs 0 on the following edge and no `done`/`err`.
  - After reset, `req`=1111 is granted to index 0.
- **Held ack.** Transmitter holds `uart_send_ack`=1 for 10 cycles.
  - Expect the arbiter to stay in RELEASE, with `uart_send_req` not re-asserted until ack has been sampled low.
